// File: rtl/sd_regs_pkg.sv
// Shared constants for the SD controller Wishbone register bank:
// word indices, reset values and the bus handshake state encoding.
package sd_regs_pkg;

    localparam int IDX_ARGUMENT     = 0;
    localparam int IDX_COMMAND      = 1;
    localparam int IDX_RESP0        = 2;
    localparam int NUM_RESP         = 4;
    localparam int IDX_CONTROL      = 6;
    localparam int IDX_CMD_TIMEOUT  = 7;
    localparam int IDX_DATA_TIMEOUT = 8;
    localparam int IDX_CLOCK_DIV    = 9;
    localparam int IDX_RESET        = 10;
    localparam int IDX_VOLTAGE      = 11;
    localparam int IDX_BLKSIZE      = 12;
    localparam int IDX_BLKCNT       = 13;
    localparam int IDX_DMA_ADDR     = 14;
    localparam int IDX_INT_BASE     = 16;

    localparam logic [7:0]  DEF_CLK_DIV    = 8'd2;
    localparam logic [11:0] DEF_BLOCK_SIZE = 12'd511;

    localparam int SUPPLY_VOLTAGE_mV = 3300;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } wb_state_e;

endpackage

// File: rtl/sd_int_channel.sv
// One interrupt channel: sticky status (set wins over write-one-to-clear),
// enable mask and the channel's combinational irq term.
module sd_int_channel #(
    parameter int INT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [INT_W-1:0] set_i,
    input  logic [INT_W-1:0] clr_i,
    input  logic             en_we_i,
    input  logic [INT_W-1:0] en_wdata_i,
    output logic [INT_W-1:0] isr_o,
    output logic [INT_W-1:0] iser_o,
    output logic             irq_o
);

    logic [INT_W-1:0] isr_q, isr_d;
    logic [INT_W-1:0] iser_q, iser_d;

    always_comb begin
        isr_d  = (isr_q & ~clr_i) | set_i;
        iser_d = en_we_i ? en_wdata_i : iser_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            isr_q  <= '0;
            iser_q <= '0;
        end else begin
            isr_q  <= isr_d;
            iser_q <= iser_d;
        end
    end

    assign isr_o  = isr_q;
    assign iser_o = iser_q;
    assign irq_o  = |(isr_q & iser_q);

endmodule

// File: rtl/sd_wb_regfile.sv
// Wishbone classic slave register bank for the SD card controller, with
// programmable ack wait states, per-channel interrupts and error on unmapped access.
module sd_wb_regfile
    import sd_regs_pkg::*;
#(
    parameter int DATA_W          = 32,
    parameter int ADDR_W          = 8,
    parameter int NUM_CH          = 2,
    parameter int INT_W           = 8,
    parameter int ACK_WAIT        = 0,
    parameter int CMD_TIMEOUT_W   = 24,
    parameter int DATA_TIMEOUT_W  = 24,
    parameter int BLKSIZE_W       = 12,
    parameter int BLKCNT_W        = 16,
    parameter logic [7:0]           RESET_CLK_DIV    = DEF_CLK_DIV,
    parameter logic [BLKSIZE_W-1:0] RESET_BLOCK_SIZE = DEF_BLOCK_SIZE,
    localparam int SEL_W          = DATA_W / 8
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_n_i,
    input  logic [DATA_W-1:0]         wb_dat_i,
    output logic [DATA_W-1:0]         wb_dat_o,
    input  logic [ADDR_W-1:0]         wb_adr_i,
    input  logic [SEL_W-1:0]          wb_sel_i,
    input  logic                      wb_we_i,
    input  logic                      wb_cyc_i,
    input  logic                      wb_stb_i,
    output logic                      wb_ack_o,
    output logic                      wb_err_o,
    output logic                      cmd_start_o,
    output logic [NUM_CH-1:0]         int_rst_o,
    input  logic [4*DATA_W-1:0]       resp_i,
    input  logic [NUM_CH*INT_W-1:0]   int_set_i,
    output logic [DATA_W-1:0]         argument_o,
    output logic [DATA_W-1:0]         command_o,
    output logic [DATA_W-1:0]         dma_addr_o,
    output logic                      control_o,
    output logic                      soft_reset_o,
    output logic [CMD_TIMEOUT_W-1:0]  cmd_timeout_o,
    output logic [DATA_TIMEOUT_W-1:0] data_timeout_o,
    output logic [7:0]                clock_div_o,
    output logic [BLKSIZE_W-1:0]      block_size_o,
    output logic [BLKCNT_W-1:0]       block_count_o,
    output logic [NUM_CH*INT_W-1:0]   int_enable_o,
    output logic                      irq_o
);

    localparam int OFF = $clog2(SEL_W);

    function automatic logic [DATA_W-1:0] lane_merge(
        input logic [DATA_W-1:0] old_v,
        input logic [DATA_W-1:0] new_v,
        input logic [SEL_W-1:0]  sel
    );
        logic [DATA_W-1:0] r;
        r = old_v;
        for (int b = 0; b < SEL_W; b++) begin
            if (sel[b]) r[8*b +: 8] = new_v[8*b +: 8];
        end
        return r;
    endfunction

    wb_state_e                 state_q;
    logic [2:0]                cnt_q;
    logic                      ack_q, err_q;
    logic [DATA_W-1:0]         rdat_q;

    logic [DATA_W-1:0]         argument_q, command_q, dma_addr_q;
    logic                      control_q, soft_reset_q;
    logic [CMD_TIMEOUT_W-1:0]  cmd_timeout_q;
    logic [DATA_TIMEOUT_W-1:0] data_timeout_q;
    logic [7:0]                clock_div_q;
    logic [BLKSIZE_W-1:0]      block_size_q;
    logic [BLKCNT_W-1:0]       block_count_q;
    logic                      pend_arg_q, cmd_start_q;
    logic [NUM_CH-1:0]         pend_isr_q, int_rst_q;
    logic                      irq_q;

    int unsigned               widx;
    logic                      req, commit, mapped, ro, bad, wr_ok, rd_ok;
    logic [NUM_CH-1:0]         isr_hit, iser_hit, en_we, irq_w;
    logic [DATA_W-1:0]         wdat_gated, rd_val;
    logic [INT_W-1:0]          isr_w [NUM_CH];
    logic [INT_W-1:0]          iser_w [NUM_CH];
    logic [INT_W-1:0]          clr [NUM_CH];
    logic [INT_W-1:0]          en_wd [NUM_CH];

    assign widx       = 32'(wb_adr_i >> OFF);
    assign req        = wb_cyc_i & wb_stb_i;
    assign wdat_gated = lane_merge('0, wb_dat_i, wb_sel_i);

    // The access takes effect on the edge that moves the handshake into ACK.
    assign commit = req && ((state_q == ST_IDLE && ACK_WAIT == 0) ||
                            (state_q == ST_WAIT && cnt_q == 3'd0));
    assign bad    = !mapped || (wb_we_i && ro);
    assign wr_ok  = commit && wb_we_i && !bad;
    assign rd_ok  = commit && !wb_we_i && !bad;

    always_comb begin
        mapped   = 1'b0;
        ro       = 1'b0;
        isr_hit  = '0;
        iser_hit = '0;
        if (widx <= IDX_DMA_ADDR) mapped = 1'b1;
        if ((widx >= IDX_RESP0 && widx < IDX_RESP0 + NUM_RESP) || widx == IDX_VOLTAGE) ro = 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
            if (widx == IDX_INT_BASE + 2*c) begin
                isr_hit[c] = 1'b1;
                mapped     = 1'b1;
            end
            if (widx == IDX_INT_BASE + 2*c + 1) begin
                iser_hit[c] = 1'b1;
                mapped      = 1'b1;
            end
        end
    end

    always_comb begin
        rd_val = '0;
        case (widx)
            IDX_ARGUMENT:     rd_val = argument_q;
            IDX_COMMAND:      rd_val = command_q;
            IDX_CONTROL:      rd_val = DATA_W'(control_q);
            IDX_CMD_TIMEOUT:  rd_val = DATA_W'(cmd_timeout_q);
            IDX_DATA_TIMEOUT: rd_val = DATA_W'(data_timeout_q);
            IDX_CLOCK_DIV:    rd_val = DATA_W'(clock_div_q);
            IDX_RESET:        rd_val = DATA_W'(soft_reset_q);
            IDX_VOLTAGE:      rd_val = DATA_W'(SUPPLY_VOLTAGE_mV);
            IDX_BLKSIZE:      rd_val = DATA_W'(block_size_q);
            IDX_BLKCNT:       rd_val = DATA_W'(block_count_q);
            IDX_DMA_ADDR:     rd_val = dma_addr_q;
            default:          rd_val = '0;
        endcase
        for (int w = 0; w < NUM_RESP; w++) begin
            if (widx == IDX_RESP0 + w) rd_val = resp_i[w*DATA_W +: DATA_W];
        end
        for (int c = 0; c < NUM_CH; c++) begin
            if (isr_hit[c])  rd_val = DATA_W'(isr_w[c]);
            if (iser_hit[c]) rd_val = DATA_W'(iser_w[c]);
        end
    end

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            clr[c]   = (wr_ok && isr_hit[c]) ? INT_W'(wdat_gated) : '0;
            en_we[c] = wr_ok && iser_hit[c];
            en_wd[c] = INT_W'(lane_merge(DATA_W'(iser_w[c]), wb_dat_i, wb_sel_i));
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        sd_int_channel #(.INT_W(INT_W)) u_ch (
            .clk_i      (wb_clk_i),
            .rst_n_i    (wb_rst_n_i),
            .set_i      (int_set_i[c*INT_W +: INT_W]),
            .clr_i      (clr[c]),
            .en_we_i    (en_we[c]),
            .en_wdata_i (en_wd[c]),
            .isr_o      (isr_w[c]),
            .iser_o     (iser_w[c]),
            .irq_o      (irq_w[c])
        );
        assign int_enable_o[c*INT_W +: INT_W] = iser_w[c];
    end

    // Handshake: IDLE -> WAIT (ACK_WAIT cycles) -> ACK (one cycle) -> IDLE.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdat_q  <= '0;
        end else begin
            ack_q  <= 1'b0;
            err_q  <= 1'b0;
            rdat_q <= '0;
            if (commit) begin
                state_q <= ST_ACK;
                ack_q   <= !bad;
                err_q   <= bad;
                rdat_q  <= rd_ok ? rd_val : '0;
            end else begin
                case (state_q)
                    ST_IDLE: if (req) begin
                        state_q <= ST_WAIT;
                        cnt_q   <= 3'(ACK_WAIT - 1);
                    end
                    ST_WAIT: if (!req) state_q <= ST_IDLE;
                             else      cnt_q   <= cnt_q - 3'd1;
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            argument_q     <= '0;
            command_q      <= '0;
            dma_addr_q     <= '0;
            control_q      <= 1'b0;
            soft_reset_q   <= 1'b0;
            cmd_timeout_q  <= '0;
            data_timeout_q <= '0;
            clock_div_q    <= RESET_CLK_DIV;
            block_size_q   <= RESET_BLOCK_SIZE;
            block_count_q  <= '0;
            pend_arg_q     <= 1'b0;
            cmd_start_q    <= 1'b0;
            pend_isr_q     <= '0;
            int_rst_q      <= '0;
            irq_q          <= 1'b0;
        end else begin
            // Side-effect pulses fire the cycle after the ACK cycle.
            pend_arg_q  <= wr_ok && widx == IDX_ARGUMENT;
            cmd_start_q <= pend_arg_q;
            pend_isr_q  <= wr_ok ? isr_hit : '0;
            int_rst_q   <= pend_isr_q;
            irq_q       <= |irq_w;
            if (wr_ok) begin
                case (widx)
                    IDX_ARGUMENT:     argument_q     <= lane_merge(argument_q, wb_dat_i, wb_sel_i);
                    IDX_COMMAND:      command_q      <= lane_merge(command_q, wb_dat_i, wb_sel_i);
                    IDX_DMA_ADDR:     dma_addr_q     <= lane_merge(dma_addr_q, wb_dat_i, wb_sel_i);
                    IDX_CONTROL:      if (wb_sel_i[0]) control_q    <= wb_dat_i[0];
                    IDX_RESET:        if (wb_sel_i[0]) soft_reset_q <= wb_dat_i[0];
                    IDX_CMD_TIMEOUT:  cmd_timeout_q  <= CMD_TIMEOUT_W'(lane_merge(DATA_W'(cmd_timeout_q), wb_dat_i, wb_sel_i));
                    IDX_DATA_TIMEOUT: data_timeout_q <= DATA_TIMEOUT_W'(lane_merge(DATA_W'(data_timeout_q), wb_dat_i, wb_sel_i));
                    IDX_CLOCK_DIV:    clock_div_q    <= 8'(lane_merge(DATA_W'(clock_div_q), wb_dat_i, wb_sel_i));
                    IDX_BLKSIZE:      block_size_q   <= BLKSIZE_W'(lane_merge(DATA_W'(block_size_q), wb_dat_i, wb_sel_i));
                    IDX_BLKCNT:       block_count_q  <= BLKCNT_W'(lane_merge(DATA_W'(block_count_q), wb_dat_i, wb_sel_i));
                    default: ;
                endcase
            end
        end
    end

    assign wb_ack_o       = ack_q;
    assign wb_err_o       = err_q;
    assign wb_dat_o       = rdat_q;
    assign cmd_start_o    = cmd_start_q;
    assign int_rst_o      = int_rst_q;
    assign irq_o          = irq_q;
    assign argument_o     = argument_q;
    assign command_o      = command_q;
    assign dma_addr_o     = dma_addr_q;
    assign control_o      = control_q;
    assign soft_reset_o   = soft_reset_q;
    assign cmd_timeout_o  = cmd_timeout_q;
    assign data_timeout_o = data_timeout_q;
    assign clock_div_o    = clock_div_q;
    assign block_size_o   = block_size_q;
    assign block_count_o  = block_count_q;

endmodule

// File: tb/tb_sd_wb_regfile.sv
// Directed bench for sd_wb_regfile with ACK_WAIT=2: vector table for plain
// register accesses plus hand sequences for interrupts and reset abort.
module tb_sd_wb_regfile;

    localparam int AW = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  dat_i, dat_o;
    logic [7:0]   adr;
    logic [3:0]   sel;
    logic         we, cyc, stb, ack, err, cmd_start, control, soft_reset, irq;
    logic [1:0]   int_rst;
    logic [127:0] resp;
    logic [15:0]  int_set, int_enable;
    logic [31:0]  argument, command, dma_addr;
    logic [23:0]  cmd_timeout, data_timeout;
    logic [7:0]   clock_div;
    logic [11:0]  block_size;
    logic [15:0]  block_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sd_wb_regfile #(.ACK_WAIT(AW)) dut (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n), .wb_dat_i(dat_i), .wb_dat_o(dat_o),
        .wb_adr_i(adr), .wb_sel_i(sel), .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb),
        .wb_ack_o(ack), .wb_err_o(err), .cmd_start_o(cmd_start), .int_rst_o(int_rst),
        .resp_i(resp), .int_set_i(int_set), .argument_o(argument), .command_o(command),
        .dma_addr_o(dma_addr), .control_o(control), .soft_reset_o(soft_reset),
        .cmd_timeout_o(cmd_timeout), .data_timeout_o(data_timeout), .clock_div_o(clock_div),
        .block_size_o(block_size), .block_count_o(block_count), .int_enable_o(int_enable),
        .irq_o(irq)
    );

    typedef struct {
        logic [31:0] rd;
        bit          ack;
        bit          err;
        int          lat;
        logic        irq_ack, irq_post, cmd_post, cmd_post2, ack_post;
        logic [1:0]  rst_post;
        logic [31:0] dat_post;
    } res_t;

    typedef struct {
        bit          we;
        int          idx;
        logic [31:0] dat;
        logic [3:0]  sel;
        bit          exp_err;
        bit          chk_rd;
        logic [31:0] exp_rd;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // set_at_commit is applied only during the cycle whose closing edge commits.
    task automatic xfer(input bit w, input int idx, input logic [31:0] d, input logic [3:0] s,
                        input logic [15:0] set_at_commit, output res_t r);
        bit done = 1'b0;
        r = '{default: '0};
        r.lat = -1;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = 8'(idx * 4); dat_i = d; sel = s;
        for (int n = 1; n <= 20 && !done; n++) begin
            @(negedge clk);
            int_set = (n == AW) ? set_at_commit : 16'h0;
            if (ack || err) begin
                done = 1'b1;
                r.lat = n; r.ack = ack; r.err = err; r.rd = dat_o; r.irq_ack = irq;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0; int_set = 16'h0;
        @(negedge clk);
        r.ack_post = ack; r.cmd_post = cmd_start; r.rst_post = int_rst;
        r.irq_post = irq; r.dat_post = dat_o;
        @(negedge clk);
        r.cmd_post2 = cmd_start;
    endtask

    vec_t vecs[23];
    res_t r;
    int   acks;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; dat_i = '0; sel = '0;
        int_set = '0;
        resp = {32'h10111213, 32'h0c0d0e0f, 32'h08090a0b, 32'h04050607};
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        chk("rst_ack", ack, 0);
        chk("rst_err", err, 0);
        chk("rst_dat", dat_o, 0);
        chk("rst_argument", argument, 0);
        chk("rst_clock_div", clock_div, 8'd2);
        chk("rst_block_size", block_size, 12'd511);
        chk("rst_irq", irq, 0);
        chk("rst_int_enable", int_enable, 0);

        // argument write: latency, single-cycle ack and cmd_start pulse
        xfer(1, 0, 32'h01020304, 4'hf, 16'h0, r);
        chk("arg_latency", r.lat, 3);
        chk("arg_ack", r.ack, 1);
        chk("arg_ack_drop", r.ack_post, 0);
        chk("arg_value", argument, 32'h01020304);
        chk("arg_cmd_start", r.cmd_post, 1);
        chk("arg_cmd_start_end", r.cmd_post2, 0);

        vecs[0]  = '{1, 14, 32'hffffffff, 4'hf, 0, 0, 32'h0};
        vecs[1]  = '{1, 14, 32'h01020304, 4'h1, 0, 0, 32'h0};
        vecs[2]  = '{0, 14, 32'h0,        4'hf, 0, 1, 32'hffffff04};
        vecs[3]  = '{1, 13, 32'hffffffff, 4'hf, 0, 0, 32'h0};
        vecs[4]  = '{1, 13, 32'h00000000, 4'h2, 0, 0, 32'h0};
        vecs[5]  = '{0, 13, 32'h0,        4'hf, 0, 1, 32'h000000ff};
        vecs[6]  = '{0, 2,  32'h0,        4'hf, 0, 1, 32'h04050607};
        vecs[7]  = '{0, 3,  32'h0,        4'hf, 0, 1, 32'h08090a0b};
        vecs[8]  = '{0, 4,  32'h0,        4'hf, 0, 1, 32'h0c0d0e0f};
        vecs[9]  = '{0, 5,  32'h0,        4'hf, 0, 1, 32'h10111213};
        vecs[10] = '{0, 11, 32'h0,        4'hf, 0, 1, 32'd3300};
        vecs[11] = '{0, 15, 32'h0,        4'hf, 1, 1, 32'h0};
        vecs[12] = '{1, 2,  32'hdeadbeef, 4'hf, 1, 0, 32'h0};
        vecs[13] = '{0, 0,  32'h0,        4'hf, 0, 1, 32'h01020304};
        vecs[14] = '{1, 7,  32'hffffffff, 4'hf, 0, 0, 32'h0};
        vecs[15] = '{0, 7,  32'h0,        4'hf, 0, 1, 32'h00ffffff};
        vecs[16] = '{1, 6,  32'hffffffff, 4'hf, 0, 0, 32'h0};
        vecs[17] = '{0, 6,  32'h0,        4'hf, 0, 1, 32'h00000001};
        vecs[18] = '{0, 9,  32'h0,        4'hf, 0, 1, 32'h00000002};
        vecs[19] = '{0, 12, 32'h0,        4'hf, 0, 1, 32'h000001ff};
        vecs[20] = '{0, 20, 32'h0,        4'hf, 1, 1, 32'h0};
        vecs[21] = '{1, 11, 32'h0,        4'hf, 1, 0, 32'h0};
        vecs[22] = '{1, 0,  32'hdeadbeef, 4'h0, 0, 0, 32'h0};

        for (int i = 0; i < 23; i++) begin
            xfer(vecs[i].we, vecs[i].idx, vecs[i].dat, vecs[i].sel, 16'h0, r);
            chk($sformatf("v%0d_latency", i), r.lat, 3);
            chk($sformatf("v%0d_ack", i), r.ack, !vecs[i].exp_err);
            chk($sformatf("v%0d_err", i), r.err, vecs[i].exp_err);
            chk($sformatf("v%0d_ack_drop", i), r.ack_post | r.dat_post != 0, 0);
            if (vecs[i].chk_rd) chk($sformatf("v%0d_rdata", i), r.rd, vecs[i].exp_rd);
        end
        chk("dma_addr_out", dma_addr, 32'hffffff04);
        chk("block_count_out", block_count, 16'h00ff);
        chk("cmd_timeout_out", cmd_timeout, 24'hffffff);
        chk("control_out", control, 1);
        chk("argument_after_sel0", argument, 32'h01020304);
        chk("command_untouched", command, 0);

        // channel 0 status set, enable, W1C
        @(negedge clk); int_set = 16'h001a;
        @(negedge clk); int_set = 16'h0;
        @(negedge clk);
        chk("irq_masked", irq, 0);
        xfer(1, 17, 32'h00000002, 4'hf, 16'h0, r);
        chk("iser0_irq_in_ack", r.irq_ack, 0);
        chk("iser0_irq_after", r.irq_post, 1);
        chk("int_enable_out", int_enable, 16'h0002);
        xfer(0, 16, 32'h0, 4'hf, 16'h0, r);
        chk("isr0_read", r.rd, 32'h1a);
        xfer(1, 16, 32'h00000002, 4'hf, 16'h0, r);
        chk("isr0_int_rst", r.rst_post, 2'b01);
        chk("isr0_irq_cleared", r.irq_post, 0);
        xfer(0, 16, 32'h0, 4'hf, 16'h0, r);
        chk("isr0_after_w1c", r.rd, 32'h18);
        chk("irq_low", irq, 0);

        // channel 1: set and clear of the same bit on the commit edge
        @(negedge clk); int_set = 16'h0100;
        @(negedge clk); int_set = 16'h0;
        xfer(0, 18, 32'h0, 4'hf, 16'h0, r);
        chk("isr1_set", r.rd, 32'h01);
        xfer(1, 18, 32'h00000001, 4'hf, 16'h0100, r);
        chk("isr1_int_rst", r.rst_post, 2'b10);
        xfer(0, 18, 32'h0, 4'hf, 16'h0, r);
        chk("isr1_set_wins", r.rd, 32'h01);
        xfer(1, 18, 32'h00000001, 4'hf, 16'h0, r);
        xfer(0, 18, 32'h0, 4'hf, 16'h0, r);
        chk("isr1_cleared", r.rd, 32'h00);

        // reset asserted while a clock_div write is waiting
        acks = 0;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 8'(9 * 4); dat_i = 32'h55; sel = 4'hf;
        @(negedge clk);
        if (ack || err) acks++;
        rst_n = 1'b0;
        @(negedge clk);
        if (ack || err) acks++;
        rst_n = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (ack || err) acks++;
        end
        chk("abort_no_ack", acks, 0);
        chk("abort_clock_div", clock_div, 8'd2);
        chk("abort_argument_reset", argument, 0);
        chk("abort_dma_reset", dma_addr, 0);
        chk("abort_enable_reset", int_enable, 0);
        xfer(1, 9, 32'h00000010, 4'h1, 16'h0, r);
        chk("clock_div_write", clock_div, 8'h10);
        xfer(0, 9, 32'h0, 4'hf, 16'h0, r);
        chk("clock_div_read", r.rd, 32'h10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
